// File: rtl/cpu_mem_interface.sv
// CPU-side memory interface: direct-mapped, write-back, write-allocate D-cache
// (64 lines x 8 words) in front of a line-based backend. Misses stall the CPU
// through mem_stall while a write-back and/or refill is serviced.
// Optional feature macro: ICACHE_EN adds a read-only I-cache sharing the backend.
module cpu_mem_interface #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned ADDR_W     = 30
) (
    input  logic                ui_clk,
    input  logic                rst,
    input  logic                dmem_read_in,
    input  logic                dmem_write_in,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic [31:0]         data_from_reg,
    input  logic [3:0]          dc_byte_w_en,
    output logic [31:0]         dmem_data_out,
    output logic                mem_stall,
    input  logic [ADDR_W-1:0]   ic_addr,
    output logic [31:0]         ic_data_out,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-4:0]   mem_addr,
    output logic [255:0]        mem_wdata,
    input  logic [255:0]        mem_rdata,
    input  logic                mem_ready
);
    localparam int unsigned NumLines = 1 << INDEX_BITS;
    localparam int unsigned TagW     = ADDR_W - INDEX_BITS - 3;

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill, StIRefill} state_e;

    state_e                  state_q, state_d;
    logic [NumLines-1:0]     valid_q, valid_d;
    logic [NumLines-1:0]     dirty_q, dirty_d;
    logic [TagW-1:0]         tag_q [NumLines];
    logic [255:0]            data_q [NumLines];
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-4:0]       mem_addr_q, mem_addr_d;
    // Line address of the miss being serviced; latched so a request change
    // mid-miss cannot redirect the fill.
    logic [ADDR_W-4:0]       miss_line_q, miss_line_d;
    logic                    stall;

    logic [INDEX_BITS-1:0]   d_idx;
    logic [2:0]              d_off;
    logic [TagW-1:0]         d_tag;
    logic [255:0]            d_line;
    logic                    d_req, d_hit, d_miss, d_commit;
    logic [INDEX_BITS-1:0]   m_idx;
    logic [TagW-1:0]         m_tag;
    logic                    ic_miss;

    logic                    data_we;
    logic [INDEX_BITS-1:0]   data_widx;
    logic [255:0]            data_wline;
    logic                    tag_we;
    logic [7:0]              wbase;

    assign d_idx  = dmem_addr[INDEX_BITS+2:3];
    assign d_off  = dmem_addr[2:0];
    assign d_tag  = dmem_addr[ADDR_W-1:INDEX_BITS+3];
    assign d_line = data_q[d_idx];
    assign d_req  = dmem_read_in | dmem_write_in;
    assign d_hit  = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
    assign d_miss = d_req && !d_hit;
    assign m_idx  = miss_line_q[INDEX_BITS-1:0];
    assign m_tag  = miss_line_q[ADDR_W-4:INDEX_BITS];
    assign wbase  = {d_off, 5'd0};

    // Write hits commit only when nothing else stalls the CPU this cycle.
    assign d_commit = (state_q == StIdle) && d_hit && dmem_write_in && !ic_miss;

    assign dmem_data_out = d_line[wbase +: 32];
    assign mem_stall     = rst & stall;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    // The victim line stays untouched during write-back, so read it directly.
    assign mem_wdata     = data_q[m_idx];

`ifdef ICACHE_EN
    logic [NumLines-1:0]     ic_valid_q, ic_valid_d;
    logic [TagW-1:0]         ic_tag_q [NumLines];
    logic [255:0]            ic_data_q [NumLines];
    logic [INDEX_BITS-1:0]   i_idx;
    logic [TagW-1:0]         i_tag;
    logic [255:0]            i_line;

    assign i_idx       = ic_addr[INDEX_BITS+2:3];
    assign i_tag       = ic_addr[ADDR_W-1:INDEX_BITS+3];
    assign i_line      = ic_data_q[i_idx];
    assign ic_miss     = !(ic_valid_q[i_idx] && (ic_tag_q[i_idx] == i_tag));
    assign ic_data_out = i_line[{ic_addr[2:0], 5'd0} +: 32];

    // I-cache valid bits: set when an instruction refill completes.
    always_comb begin
        ic_valid_d = ic_valid_q;
        if (state_q == StIRefill && mem_ready) begin
            ic_valid_d[m_idx] = 1'b1;
        end
    end

    // I-cache valid register, cleared by reset.
    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            ic_valid_q <= '0;
        end else begin
            ic_valid_q <= ic_valid_d;
        end
    end

    // I-cache tag and data storage, written on instruction refill.
    always_ff @(posedge ui_clk) begin
        if (state_q == StIRefill && mem_ready) begin
            ic_data_q[m_idx] <= mem_rdata;
            ic_tag_q[m_idx]  <= m_tag;
        end
    end
`else
    logic unused_ic;
    assign unused_ic   = ^ic_addr;
    assign ic_miss     = 1'b0;
    assign ic_data_out = '0;
`endif

    // D-cache array write port: byte-merge on a write hit, full line on refill.
    always_comb begin
        data_we    = 1'b0;
        tag_we     = 1'b0;
        data_widx  = d_idx;
        data_wline = d_line;
        if (state_q == StRefill && mem_ready) begin
            data_we    = 1'b1;
            tag_we     = 1'b1;
            data_widx  = m_idx;
            data_wline = mem_rdata;
        end else if (d_commit) begin
            data_we = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (dc_byte_w_en[i]) begin
                    data_wline[wbase + 8'(8 * i) +: 8] = data_from_reg[8 * i +: 8];
                end
            end
        end
    end

    // D-cache tag and data storage (not reset; validity lives in valid_q).
    always_ff @(posedge ui_clk) begin
        if (data_we) begin
            data_q[data_widx] <= data_wline;
        end
        if (tag_we) begin
            tag_q[data_widx] <= m_tag;
        end
    end

    // Miss-handling FSM next state, backend request and stall generation.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        miss_line_d = miss_line_q;
        stall       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (d_miss) begin
                    stall       = 1'b1;
                    mem_req_d   = 1'b1;
                    miss_line_d = dmem_addr[ADDR_W-1:3];
                    if (valid_q[d_idx] && dirty_q[d_idx]) begin
                        state_d    = StWriteback;
                        mem_we_d   = 1'b1;
                        mem_addr_d = {tag_q[d_idx], d_idx};
                    end else begin
                        state_d    = StRefill;
                        mem_we_d   = 1'b0;
                        mem_addr_d = dmem_addr[ADDR_W-1:3];
                    end
`ifdef ICACHE_EN
                end else if (ic_miss) begin
                    stall       = 1'b1;
                    state_d     = StIRefill;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ic_addr[ADDR_W-1:3];
                    miss_line_d = ic_addr[ADDR_W-1:3];
`endif
                end else if (d_commit) begin
                    dirty_d[d_idx] = 1'b1;
                end
            end
            StWriteback: begin
                stall = 1'b1;
                if (mem_ready) begin
                    // Refill request follows back-to-back; mem_req stays high.
                    dirty_d[m_idx] = 1'b0;
                    state_d        = StRefill;
                    mem_we_d       = 1'b0;
                    mem_addr_d     = miss_line_q;
                end
            end
            StRefill: begin
                stall = 1'b1;
                if (mem_ready) begin
                    valid_d[m_idx] = 1'b1;
                    dirty_d[m_idx] = 1'b0;
                    mem_req_d      = 1'b0;
                    state_d        = StIdle;
                end
            end
`ifdef ICACHE_EN
            StIRefill: begin
                stall = 1'b1;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
`endif
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // FSM and control state; reset abandons any in-flight backend transaction.
    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            miss_line_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            miss_line_q <= miss_line_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_interface.sv
// Scoreboard bench for cpu_mem_interface: expected read data and backend
// transactions are queued by the stimulus and popped by independent monitors.
module tb_cpu_mem_interface;
    localparam int Lat = 5;

    typedef struct packed {
        logic        we;
        logic [26:0] addr;
        logic [31:0] wd0;
    } txn_t;

    logic         ui_clk = 1'b0;
    logic         rst;
    logic         dmem_read_in, dmem_write_in;
    logic [29:0]  dmem_addr, ic_addr;
    logic [31:0]  data_from_reg, dmem_data_out, ic_data_out;
    logic [3:0]   dc_byte_w_en;
    logic         mem_stall, mem_req, mem_we, mem_ready;
    logic [26:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata, bk_line;

    txn_t         exp_mem[$];
    logic [31:0]  exp_rd[$];
    int           checks = 0;
    int           failures = 0;

    cpu_mem_interface dut (
        .ui_clk(ui_clk), .rst(rst),
        .dmem_read_in(dmem_read_in), .dmem_write_in(dmem_write_in),
        .dmem_addr(dmem_addr), .data_from_reg(data_from_reg),
        .dc_byte_w_en(dc_byte_w_en), .dmem_data_out(dmem_data_out),
        .mem_stall(mem_stall), .ic_addr(ic_addr), .ic_data_out(ic_data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32 * k +: 32] = base + 32'(k);
        return l;
    endfunction

    // Backend model: checks each new request against the queue, replies after Lat cycles.
    initial begin
        txn_t act, exp;
        bit   ab;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge ui_clk);
            if (rst && mem_req) begin
                act.we   = mem_we;
                act.addr = mem_addr;
                act.wd0  = mem_we ? mem_wdata[31:0] : 32'h0;
                if (exp_mem.size() == 0) begin
                    fail_now("mem_txn_unexpected");
                end else begin
                    exp = exp_mem.pop_front();
                    check("mem_txn", 64'(act), 64'(exp));
                end
                ab = 1'b0;
                for (int i = 0; i < Lat; i++) begin
                    @(negedge ui_clk);
                    if (!rst || !mem_req) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (!ab) begin
                    mem_ready = 1'b1;
                    mem_rdata = bk_line;
                    @(posedge ui_clk);
                    #1 mem_ready = 1'b0;
                end
            end
        end
    end

    // Read monitor: a non-stalled pure read presents data to compare.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge ui_clk);
            if (rst && dmem_read_in && !dmem_write_in && !mem_stall) begin
                if (exp_rd.size() == 0) begin
                    fail_now("rd_unexpected");
                end else begin
                    e = exp_rd.pop_front();
                    check("rd_data", 64'(dmem_data_out), 64'(e));
                end
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit exp_miss, output logic [31:0] seen);
        int n;
        @(posedge ui_clk);
        #1;
        dmem_read_in  = rd;
        dmem_write_in = wr;
        dmem_addr     = a;
        data_from_reg = d;
        dc_byte_w_en  = be;
        @(negedge ui_clk);
        check("miss_flag", 64'(mem_stall), 64'(exp_miss));
        n = 0;
        while (mem_stall && n < 100) begin
            @(negedge ui_clk);
            n++;
        end
        if (mem_stall) fail_now("stall_timeout");
        seen = dmem_data_out;
        @(posedge ui_clk);
        #1;
        dmem_read_in  = 1'b0;
        dmem_write_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seen;
        int n;
        rst = 1'b0;
        dmem_read_in = 1'b1;
        dmem_write_in = 1'b0;
        dmem_addr = '0;
        ic_addr = '0;
        data_from_reg = '0;
        dc_byte_w_en = '0;
        bk_line = '0;
        repeat (3) @(negedge ui_clk);
        check("rst_stall", 64'(mem_stall), 64'd0);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        dmem_read_in = 1'b0;
        @(negedge ui_clk);
        rst = 1'b1;

        // Cold write-allocate to addr 0, then read back.
        bk_line = '0;
        exp_mem.push_back('{we: 1'b0, addr: 27'd0, wd0: 32'h0});
        access(1'b0, 1'b1, 30'd0, 32'h0000_0001, 4'b1111, 1'b1, seen);
        exp_rd.push_back(32'h0000_0001);
        access(1'b1, 1'b0, 30'd0, 32'h0, 4'b0000, 1'b0, seen);

        // Conflicting read evicts dirty line 0.
        bk_line = make_line(32'h1111_0000);
        exp_mem.push_back('{we: 1'b1, addr: 27'd0, wd0: 32'h0000_0001});
        exp_mem.push_back('{we: 1'b0, addr: 27'd64, wd0: 32'h0});
        exp_rd.push_back(32'h1111_0000);
        access(1'b1, 1'b0, 30'd512, 32'h0, 4'b0000, 1'b1, seen);
        exp_rd.push_back(32'h1111_0003);
        access(1'b1, 1'b0, 30'd515, 32'h0, 4'b0000, 1'b0, seen);

        // Byte-enable merge.
        access(1'b0, 1'b1, 30'd513, 32'h0000_0001, 4'b1111, 1'b0, seen);
        access(1'b0, 1'b1, 30'd513, 32'hAABB_CCDD, 4'b0010, 1'b0, seen);
        exp_rd.push_back(32'h0000_CC01);
        access(1'b1, 1'b0, 30'd513, 32'h0, 4'b0000, 1'b0, seen);

        // Read and write together behave as a write.
        bk_line = make_line(32'h2222_0000);
        exp_mem.push_back('{we: 1'b0, addr: 27'd1, wd0: 32'h0});
        exp_rd.push_back(32'h2222_0000);
        access(1'b1, 1'b0, 30'd8, 32'h0, 4'b0000, 1'b1, seen);
        access(1'b1, 1'b1, 30'd8, 32'h0000_0080, 4'b1111, 1'b0, seen);
        check("pre_write_word", 64'(seen), 64'h2222_0000);
        exp_rd.push_back(32'h0000_0080);
        access(1'b1, 1'b0, 30'd8, 32'h0, 4'b0000, 1'b0, seen);

        // Reset during refill.
        bk_line = make_line(32'h3333_0000);
        exp_mem.push_back('{we: 1'b0, addr: 27'd2, wd0: 32'h0});
        @(posedge ui_clk);
        #1;
        dmem_read_in = 1'b1;
        dmem_addr = 30'd16;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge ui_clk);
            n++;
        end
        if (!mem_req) fail_now("refill_req_timeout");
        repeat (2) @(negedge ui_clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_req", 64'(mem_req), 64'd0);
        check("midrst_stall", 64'(mem_stall), 64'd0);
        dmem_read_in = 1'b0;
        repeat (2) @(negedge ui_clk);
        #2 rst = 1'b1;

        exp_mem.push_back('{we: 1'b0, addr: 27'd0, wd0: 32'h0});
        exp_rd.push_back(32'h3333_0000);
        access(1'b1, 1'b0, 30'd0, 32'h0, 4'b0000, 1'b1, seen);
        exp_mem.push_back('{we: 1'b0, addr: 27'd64, wd0: 32'h0});
        exp_rd.push_back(32'h3333_0000);
        access(1'b1, 1'b0, 30'd512, 32'h0, 4'b0000, 1'b1, seen);

        repeat (5) @(negedge ui_clk);
        check("exp_rd_drained", 64'(exp_rd.size()), 64'd0);
        check("exp_mem_drained", 64'(exp_mem.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_mem_interface.md
Name: cpu_mem_interface

Overview:
- CPU-side memory interface that sits between the pipeline's data port (and, optionally, its instruction port) and a line-based memory backend; the DDR2 controller wrapper supplies the clock.
- Implements a direct-mapped, write-back, write-allocate data cache with a 32-bit word port and per-byte write enables.
- Stalls the CPU with `mem_stall` while a miss is being serviced.

Parameters:
- INDEX_BITS, 6, log2 of the number of cache lines (64 lines)
- ADDR_W, 30, CPU word-address width
- Fixed geometry: 8 words (256 bits) per line; word offset = addr[2:0]; tag = addr[ADDR_W-1:INDEX_BITS+3]

Ports:
- ui_clk  in  1  sole clock (from the DDR controller wrapper)
- rst  in  1  asynchronous, active-low reset
- dmem_read_in  in  1  data read request
- dmem_write_in  in  1  data write request
- dmem_addr  in  30  data word address
- data_from_reg  in  32  write data
- dc_byte_w_en  in  4  byte enables; bit i covers bits [8i+7:8i]
- dmem_data_out  out  32  read data, word at dmem_addr
- mem_stall  out  1  CPU must hold its request while high
- ic_addr  in  30  instruction word address (ICACHE_EN only)
- ic_data_out  out  32  instruction word
- mem_req  out  1  backend request, held until mem_ready
- mem_we  out  1  1 = line write-back, 0 = line refill
- mem_addr  out  27  line address, i.e. word address >> 3
- mem_wdata  out  256  line being written back; word k at bits [32k+31:32k]
- mem_rdata  in  256  refill line, valid when mem_ready
- mem_ready  in  1  one-cycle completion pulse for the current request

Behaviour:
Reset:
- On rst=0, asynchronously clear all valid and dirty bits, set state=IDLE, and drive mem_req=0, mem_we=0.
- While rst=0, mem_stall=0.
- Data arrays are not reset.

Hits:
- Tag, valid and dirty bits are held in registers; data arrays use combinational read.
- Hit = valid[index] && tag match.
- dmem_data_out always shows the word for dmem_addr combinationally. Its value is undefined on a miss.
- If dmem_read_in and dmem_write_in are both 1, the access is a write. dmem_data_out then shows the pre-write word.
- Read hit: data valid in the same cycle, mem_stall=0.
- Write hit: mem_stall=0. At the next edge, each enabled byte of data_from_reg is merged into the line and dirty[index] is set to 1.
- No request (both enables 0): mem_stall=0 and no state change.

State machine (IDLE, WRITEBACK, REFILL):
- IDLE, request present, miss: mem_stall=1 combinationally.
  - Line dirty: next state WRITEBACK; mem_req=1, mem_we=1, mem_addr={old tag, index}, mem_wdata=old line.
  - Line clean or invalid: next state REFILL; mem_req=1, mem_we=0, mem_addr=dmem_addr[29:3].
- WRITEBACK: hold all mem_* outputs. On mem_ready: clear dirty, go to REFILL with the refill request issued at that edge.
- REFILL: on mem_ready, store mem_rdata, write the new tag, set valid=1 and dirty=0, drop mem_req, and return to IDLE.
- The access then hits in the following cycle and is completed as a normal hit (write-allocate).
- mem_stall stays 1 in WRITEBACK and REFILL.

Latency and handshake:
- Clean miss stalls 2 cycles plus the backend latency.
- Dirty miss adds a write-back transaction before the refill.
- The CPU must keep address, data and enables stable while mem_stall=1. A request change mid-miss does not abort the fill.
- Backend handshake: mem_req rises at an edge and falls at the edge on which mem_ready=1 is sampled. mem_ready while mem_req=0 is ignored.

Reset mid-transaction:
- Reset during WRITEBACK or REFILL abandons the transaction.
- mem_req drops immediately and all lines become invalid.

Optional Feature:
ICACHE_EN
- Defined: adds a read-only direct-mapped I-cache with the same geometry, indexed by ic_addr.
  - An I-miss also raises mem_stall.
  - The I-cache shares the backend port; a D-side miss pending in the same cycle wins.
  - ic_data_out is combinational on a hit.
- Undefined: ic_addr is ignored, ic_data_out=0, and there is no I-cache storage.

Test Plan:
- Reset: rst=0 then 1 -> mem_stall=0, mem_req=0, mem_we=0; first read of addr 0 misses.
- Write to cold addr 0 (data 0x00000001, be 4'b1111) -> mem_req=1, mem_we=0, mem_addr=0. Backend returns all zeros with mem_ready after 5 cycles. mem_stall stays high until the refill, then the write completes; a following read of addr 0 returns 0x00000001 with mem_stall=0.
- Read of conflicting addr 512 (same index 0, tag 1) -> write-back first: mem_we=1, mem_addr=0, mem_wdata[31:0]=0x00000001. Then refill with mem_addr=64; read data = backend word.
- Byte-enable write: line word holds 0x00000001; write 0xAABBCCDD with be 4'b0010 -> read returns 0x0000CC01.
- dmem_read_in=1 and dmem_write_in=1 on a hit at addr 8, data 0x80 -> treated as a write; a later read returns 0x00000080.
- Assert rst=0 during REFILL -> mem_req falls immediately; after release, addr 0 misses again.
